// File: rtl/wishbone_peripheral_to_axi_pkg.sv
// Shared types for the Wishbone-write to AXI-Stream peripheral: FSM state encoding
// and a parameter sanity helper.
package wishbone_peripheral_to_axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_SPACE = 2'd1,
    ST_ACK        = 2'd2,
    ST_ERR        = 2'd3
  } wb_axi_state_e;

  function automatic bit is_pow2_ge2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/wishbone_peripheral_to_axi_if.sv
// Bus bundle for the peripheral: Wishbone classic slave side plus the AXI-Stream source.
interface wishbone_peripheral_to_axi_if #(
  parameter int DATA_WIDTH = 8
);
  localparam int SEL_W = (DATA_WIDTH >= 8) ? DATA_WIDTH / 8 : 1;

  logic                  in_wb_cyc;
  logic                  in_wb_stb;
  logic                  in_wb_we;
  logic [SEL_W-1:0]      in_wb_sel;
  logic [DATA_WIDTH-1:0] in_wb_dat;
  logic                  out_wb_ack;
  logic                  out_wb_err;
  logic [DATA_WIDTH-1:0] out_wb_dat;

  // Stream handshake: a word transfers on any rising edge where valid & ready are both
  // high; once valid rises, valid and data stay stable until that transfer happens.
  logic                  out_source_valid;
  logic                  in_source_ready;
  logic [DATA_WIDTH-1:0] out_source_data;

  modport slave (
    input  in_wb_cyc, in_wb_stb, in_wb_we, in_wb_sel, in_wb_dat, in_source_ready,
    output out_wb_ack, out_wb_err, out_wb_dat, out_source_valid, out_source_data
  );

  modport master (
    output in_wb_cyc, in_wb_stb, in_wb_we, in_wb_sel, in_wb_dat, in_source_ready,
    input  out_wb_ack, out_wb_err, out_wb_dat, out_source_valid, out_source_data
  );

endinterface

// File: rtl/wishbone_peripheral_to_axi_sync_fifo.sv
// Single-clock FIFO with first-word fall-through head; pushes into a full FIFO and pops
// from an empty one are dropped.
module wb_axi_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               push_i,
  input  logic [DATA_WIDTH-1:0]              push_data_i,
  input  logic                               pop_i,
  output logic [DATA_WIDTH-1:0]              head_o,
  output logic                               full_o,
  output logic                               empty_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    count_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Head reads as zero while empty so the stream data is clean after reset and drain.
  assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/wishbone_peripheral_to_axi.sv
// Wishbone classic write slave feeding an AXI-Stream source through a small FIFO.
// Optional WB_TO_AXI_STATUS_EN: full-width reads are acked and return the FIFO count.
module wishbone_peripheral_to_axi
  import wishbone_peripheral_to_axi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            in_clock,
  input  logic                            in_reset,
  wishbone_peripheral_to_axi_if.slave     bus,
  output wb_axi_state_e                   out_dbg_state,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] out_dbg_count
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  if ((DATA_WIDTH < 8) || ((DATA_WIDTH % 8) != 0)) begin : g_bad_width
    $error("wishbone_peripheral_to_axi: DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (!is_pow2_ge2(FIFO_DEPTH)) begin : g_bad_depth
    $error("wishbone_peripheral_to_axi: FIFO_DEPTH must be a power of two >= 2");
  end

  wb_axi_state_e    state_q, state_d;
  logic             push, pop;
  logic             all_sel, space, read_ok;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  assign all_sel = &bus.in_wb_sel;
  // Space comes from the registered count, so a same-edge pop never frees a slot early.
  assign space   = !fifo_full;
  assign pop     = !fifo_empty && bus.in_source_ready;

`ifdef WB_TO_AXI_STATUS_EN
  assign read_ok = !bus.in_wb_we && all_sel;
`else
  assign read_ok = 1'b0;
`endif

  wb_axi_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (in_clock),
    .rst_i       (in_reset),
    .push_i      (push),
    .push_data_i (bus.in_wb_dat),
    .pop_i       (pop),
    .head_o      (bus.out_source_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_wb_cyc && bus.in_wb_stb) begin
          if (bus.in_wb_we && all_sel) begin
            if (space) begin
              push    = 1'b1;
              state_d = ST_ACK;
            end else begin
              state_d = ST_WAIT_SPACE;
            end
          end else if (read_ok) begin
            state_d = ST_ACK;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      // Master withdrawing the cycle wins over a slot freeing up in the same cycle.
      ST_WAIT_SPACE: begin
        if (!bus.in_wb_cyc) begin
          state_d = ST_IDLE;
        end else if (space) begin
          push    = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  assign bus.out_wb_ack       = (state_q == ST_ACK);
  assign bus.out_wb_err       = (state_q == ST_ERR);
  assign bus.out_source_valid = !fifo_empty;
  assign out_dbg_state        = state_q;
  assign out_dbg_count        = fifo_count;

`ifdef WB_TO_AXI_STATUS_EN
  assign bus.out_wb_dat = (bus.out_wb_ack && bus.in_wb_cyc && !bus.in_wb_we)
                          ? DATA_WIDTH'(fifo_count) : '0;
`else
  assign bus.out_wb_dat = '0;
`endif

endmodule
